// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic-array feeder blocks.
//   DATA_W_DEF - default element width
//   state_t    - feeder FSM state (IDLE, FEED)
//   cnt_w()    - width of a counter that must hold values 0..n-1
package systolic_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      FEED = 1'b1
   } state_t;

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/feeder_lane.sv
// feeder_lane: element selection for one systolic row (channel CH).
// The channel is active while CH <= t <= CH+DEPTH-1 and then presents
// element (t-CH), or DEPTH-1-(t-CH) when reversed. Purely combinational
// on registered state held in the parent.
//   t         - feed step counter
//   state     - feeder FSM state
//   reverse   - emit the channel's elements last-to-first
//   lane_tile - this channel's DEPTH elements, element k at [k*DATA_W +: DATA_W]
//   data      - selected element, 0 when inactive
//   valid     - element-valid for this channel
module feeder_lane
   import systolic_pkg::*;
#(
   parameter int CH     = 0,
   parameter int DEPTH  = 7,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TW     = 4
) (
   input  logic [TW-1:0]           t,
   input  state_t                  state,
   input  logic                    reverse,
   input  logic [DEPTH*DATA_W-1:0] lane_tile,
   output logic [DATA_W-1:0]       data,
   output logic                    valid
);

   localparam logic [31:0] LO = 32'(CH);

   logic [31:0] idx;
   logic [31:0] sel;

   always_comb begin
      data  = '0;
      valid = 1'b0;
      // Unsigned wrap makes t < CH a huge index, so one compare covers
      // both the lower and the upper bound of the active window.
      idx   = 32'(t) - LO;
      sel   = reverse ? (32'(DEPTH - 1) - idx) : idx;
      if (state == FEED && idx < 32'(DEPTH)) begin
         valid = 1'b1;
         for (int k = 0; k < DEPTH; k++) begin
            if (sel == 32'(k)) data = lane_tile[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: accepts a NUM_CH x DEPTH tile and streams it into the rows
// of a systolic array with a one-step skew per channel (channel c starts at
// step c), taking DEPTH+NUM_CH-1 enabled steps per tile.
//   clk, reset_n      - clock, asynchronous active-low reset
//   load_valid/ready  - tile handshake; ready only while IDLE
//   load_data         - tile, element k of channel c at (c*DEPTH+k)*DATA_W
//   load_reverse      - sampled with the tile; emit elements last-to-first
//   enable            - advance one step; low stalls with outputs held
//   abort             - abandon the tile (priority over enable and load)
//   data_out/valid_out- per-channel element and valid, from registers only
//   done              - one-cycle pulse after the last step
module skew_feeder
   import systolic_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 7,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [NUM_CH*DEPTH*DATA_W-1:0] load_data,
   input  logic                           load_reverse,
   input  logic                           enable,
   input  logic                           abort,
   output logic [NUM_CH*DATA_W-1:0]       data_out,
   output logic [NUM_CH-1:0]              valid_out,
   output logic                           done
);

   localparam int            TW   = cnt_w(DEPTH + NUM_CH);
   localparam logic [TW-1:0] LAST = TW'(DEPTH + NUM_CH - 2);

   state_t                          state;
   logic [TW-1:0]                   t;
   logic                            reverse;
   logic [NUM_CH*DEPTH*DATA_W-1:0]  tile;

   assign load_ready = (state == IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         t       <= '0;
         reverse <= 1'b0;
         tile    <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // Drops the tile; done stays low since it defaults to 0 above.
            state <= IDLE;
            t     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_valid) begin
                     tile    <= load_data;
                     reverse <= load_reverse;
                     t       <= '0;
                     state   <= FEED;
                  end
               end
               FEED: begin
                  // load_valid is ignored here so the held tile stays intact.
                  if (enable) begin
                     if (t == LAST) begin
                        state <= IDLE;
                        t     <= '0;
                        done  <= 1'b1;
                     end else begin
                        t <= t + TW'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      feeder_lane #(
         .CH     (c),
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W),
         .TW     (TW)
      ) u_lane (
         .t         (t),
         .state     (state),
         .reverse   (reverse),
         .lane_tile (tile[c*DEPTH*DATA_W +: DEPTH*DATA_W]),
         .data      (data_out[c*DATA_W +: DATA_W]),
         .valid     (valid_out[c])
      );
   end

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: scoreboard bench for skew_feeder (NUM_CH=4, DEPTH=7,
// DATA_W=8). Each driven cycle pushes the expected post-edge outputs;
// a monitor pops and compares them just after every rising edge.
module tb_skew_feeder;

   localparam int NC   = 4;
   localparam int DP   = 7;
   localparam int DW   = 8;
   localparam int LAST = DP + NC - 2;

   logic                    clk;
   logic                    reset_n;
   logic                    load_valid;
   logic                    load_ready;
   logic [NC*DP*DW-1:0]     load_data;
   logic                    load_reverse;
   logic                    enable;
   logic                    abort;
   logic [NC*DW-1:0]        data_out;
   logic [NC-1:0]           valid_out;
   logic                    done;

   skew_feeder #(.NUM_CH(NC), .DEPTH(DP), .DATA_W(DW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_reverse (load_reverse),
      .enable       (enable),
      .abort        (abort),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NC*DW-1:0] data;
      logic [NC-1:0]    valid;
      logic             done;
      logic             ready;
   } rec_t;

   rec_t q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_feed, m_rev, m_done;
   int m_t, m_off;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] elem(input int c, input int k, input int off);
      return 8'(16*c + k + 1 + off);
   endfunction

   task automatic set_tile(input int off);
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < DP; k++)
            load_data[(c*DP+k)*DW +: DW] = elem(c, k, off);
   endtask

   task automatic model_reset();
      m_feed = 0; m_rev = 0; m_done = 0; m_t = 0; m_off = 0;
   endtask

   // Drive inputs for the next edge and push the outputs expected after it.
   task automatic drive(input bit lv, input bit lrev, input int off, input bit en, input bit ab);
      rec_t r;
      int   k;
      load_valid = lv; load_reverse = lrev; enable = en; abort = ab;
      set_tile(off);
      if (ab) begin
         m_feed = 0; m_done = 0;
      end else if (!m_feed) begin
         m_done = 0;
         if (lv) begin m_feed = 1; m_t = 0; m_rev = lrev; m_off = off; end
      end else if (en) begin
         if (m_t == LAST) begin m_feed = 0; m_done = 1; end
         else begin m_t++; m_done = 0; end
      end else begin
         m_done = 0;
      end
      r.data = '0; r.valid = '0;
      if (m_feed) begin
         for (int c = 0; c < NC; c++) begin
            if (m_t >= c && m_t <= c + DP - 1) begin
               k = m_rev ? (DP - 1 - (m_t - c)) : (m_t - c);
               r.data[c*DW +: DW] = elem(c, k, m_off);
               r.valid[c] = 1'b1;
            end
         end
      end
      r.done  = m_done;
      r.ready = !m_feed;
      q.push_back(r);
   endtask

   task automatic cyc(input bit lv, input bit lrev, input int off, input bit en, input bit ab);
      @(negedge clk);
      drive(lv, lrev, off, en, ab);
   endtask

   // check outputs shortly after the edge that the last cyc() targets
   task automatic peek(input string tag, input logic [31:0] d, input logic [3:0] v);
      @(posedge clk);
      #2;
      chk({tag, "_data"}, 64'(data_out), 64'(d));
      chk({tag, "_valid"}, 64'(valid_out), 64'(v));
   endtask

   always @(posedge clk) begin
      rec_t r;
      #1;
      if (reset_n && q.size() > 0) begin
         r = q.pop_front();
         chk("sb_data", 64'(data_out), 64'(r.data));
         chk("sb_valid", 64'(valid_out), 64'(r.valid));
         chk("sb_done", 64'(done), 64'(r.done));
         chk("sb_ready", 64'(load_ready), 64'(r.ready));
      end
   end

   initial begin
      reset_n = 1'b0; load_valid = 1'b1; load_reverse = 1'b0;
      enable = 1'b1; abort = 1'b0;
      set_tile(0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_data", 64'(data_out), 64'h0);
      chk("rst_valid", 64'(valid_out), 64'h0);
      chk("rst_done", 64'(done), 64'h0);

      // release and load on the very first edge
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_ready", 64'(load_ready), 64'h1);
      drive(1, 0, 0, 1, 0);

      // forward tile, enable held
      for (int i = 1; i <= LAST; i++) begin
         cyc(0, 0, 0, 1, 0);
         if (i == 3) peek("fwd_t3", 32'h31221304, 4'b1111);
         if (i == 9) peek("fwd_t9", 32'h37000000, 4'b1000);
      end
      cyc(0, 0, 0, 1, 0);              // edge -> done cycle
      // reverse tile offered on the done cycle
      cyc(1, 1, 0, 1, 0);
      peek("rev_t0", 32'h00000007, 4'b0001);
      for (int i = 1; i <= LAST; i++) begin
         cyc(1, 0, 'h80, 1, 0);        // loads during FEED must be ignored
         if (i == 9) peek("rev_t9", 32'h31000000, 4'b1000);
      end
      cyc(0, 0, 0, 1, 0);              // done

      // stall for 3 cycles at t=5
      cyc(1, 0, 'h20, 1, 0);
      for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      peek("stall_t5", 32'h53443526, 4'b1111);
      for (int i = 6; i <= LAST; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);              // done

      // abort at t=4, reload on the next cycle
      cyc(1, 0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      peek("abort", 32'h0, 4'b0000);
      cyc(1, 0, 'h10, 1, 0);
      for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, 0);

      // asynchronous reset mid-FEED
      @(posedge clk);
      #3;
      load_valid = 1'b0; enable = 1'b0; abort = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_data", 64'(data_out), 64'h0);
      chk("mid_rst_valid", 64'(valid_out), 64'h0);
      chk("mid_rst_ready", 64'(load_ready), 64'h1);
      model_reset();
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 1, 'h30, 1, 0);
      for (int i = 1; i <= LAST; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);              // done

      // abort in IDLE blocks a load
      cyc(1, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 0);
      @(posedge clk);
      #3;
      chk("sb_drained", 64'(q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
